// File: rtl/icache_refill_unit_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_unit_pkg
//   Shared instruction-cache definitions: the controller state type, the
//   refill engine state type and the default line/refill geometry.
//   No ports (package).
// -----------------------------------------------------------------------------
package icache_refill_unit_pkg;

    localparam int ICACHE_LINE_WIDTH   = 128;
    localparam int ICACHE_BUS_WIDTH    = 32;
    localparam int ICACHE_REFILL_BEATS = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;

    // Top-level icache controller states.
    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_COMPARE = 2'd1,
        ICACHE_MISS    = 2'd2,
        ICACHE_REFILL  = 2'd3
    } type_icache_states_e;

    // Line refill engine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } type_icache_refill_states_e;

endpackage

// File: rtl/icache_refill_unit.sv
// -----------------------------------------------------------------------------
// icache_refill_unit
//   Fetches one instruction-cache line from a narrow memory bus as BEATS
//   consecutive reads, assembles it and hands it to the icache controller.
//
// Ports
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   icache2mem_req_i   refill request (level, held until acked or killed)
//   icache2mem_addr_i  miss address (line offset bits ignored)
//   mem2icache_ack_o   one-cycle pulse: mem2icache_data_o holds a valid line
//   mem2icache_data_o  assembled line, beat 0 in the LSBs
//   bus_req_o          bus read request
//   bus_addr_o         byte address of the current beat
//   bus_ack_i          beat accepted, bus_rdata_i valid this cycle
//   bus_rdata_i        beat read data
//   dbg_state_o        current refill state (debug observation)
//
// Handshake: a beat transfers on a rising edge where bus_req_o=1 and
// bus_ack_i=1. While bus_req_o=1 and bus_ack_i=0, bus_addr_o is held stable.
// Once a beat is requested it is always completed, even if the refill is
// killed; a killed refill never raises mem2icache_ack_o.
// -----------------------------------------------------------------------------
module icache_refill_unit #(
    parameter int ICACHE_LINE_WIDTH = 128,
    parameter int BUS_DATA_WIDTH    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         icache2mem_req_i,
    input  logic [31:0]                  icache2mem_addr_i,
    output logic                         mem2icache_ack_o,
    output logic [ICACHE_LINE_WIDTH-1:0] mem2icache_data_o,
    output logic                         bus_req_o,
    output logic [31:0]                  bus_addr_o,
    input  logic                         bus_ack_i,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_rdata_i,
    output logic [1:0]                   dbg_state_o
);
    import icache_refill_unit_pkg::*;

    localparam int BEATS           = ICACHE_LINE_WIDTH / BUS_DATA_WIDTH;
    localparam int CNT_W           = $clog2(BEATS);
    localparam int LINE_BYTES_LOG2 = $clog2(ICACHE_LINE_WIDTH / 8);
    localparam int BEAT_BYTES_LOG2 = $clog2(BUS_DATA_WIDTH / 8);

    type_icache_refill_states_e state_q;
    logic [CNT_W-1:0]           beat_cnt_q;
    logic [31:0]                line_addr_q;
    logic [31:0]                aligned_addr;
    logic                       last_beat;
    logic                       unused_offset;

    assign aligned_addr  = {icache2mem_addr_i[31:LINE_BYTES_LOG2], {LINE_BYTES_LOG2{1'b0}}};
    assign unused_offset = ^icache2mem_addr_i[LINE_BYTES_LOG2-1:0];
    assign last_beat     = (beat_cnt_q == CNT_W'(BEATS - 1));

    // Outputs decoded purely from registers: no input-to-output paths.
    assign bus_req_o        = (state_q == FETCH) || (state_q == ABORT);
    assign mem2icache_ack_o = (state_q == DONE);
    assign bus_addr_o       = line_addr_q + ({{(32 - CNT_W){1'b0}}, beat_cnt_q} << BEAT_BYTES_LOG2);
    assign dbg_state_o      = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            beat_cnt_q        <= '0;
            line_addr_q       <= '0;
            mem2icache_data_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (icache2mem_req_i) begin
                        line_addr_q <= aligned_addr;
                        beat_cnt_q  <= '0;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus_ack_i) begin
                        mem2icache_data_o[int'(beat_cnt_q) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_rdata_i;
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        // A kill coinciding with an accepted beat leaves nothing
                        // outstanding, so return straight to IDLE.
                        if (!icache2mem_req_i) begin
                            state_q <= IDLE;
                        end else if (last_beat) begin
                            state_q <= DONE;
                        end
                    end else if (!icache2mem_req_i) begin
                        // Beat still outstanding on the bus: finish it in ABORT.
                        state_q <= ABORT;
                    end
                end
                ABORT: begin
                    // beat_cnt_q is frozen so bus_addr_o stays on the orphan beat.
                    if (bus_ack_i) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_unit
//   Directed bench for icache_refill_unit (128-bit line, 32-bit bus, 4 beats).
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   before the inputs for the next rising edge are applied. "k" counts falling
//   edges after the rising edge that samples the request.
// -----------------------------------------------------------------------------
module tb_icache_refill_unit;
    import icache_refill_unit_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [31:0]  addr;
    logic         ack;
    logic [127:0] line;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_ack;
    logic [31:0]  rdata;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0]  D_A [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    localparam logic [127:0] LINE_A  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [31:0]  D_B [4] = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    localparam logic [127:0] LINE_B  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

    icache_refill_unit #(
        .ICACHE_LINE_WIDTH(128),
        .BUS_DATA_WIDTH   (32)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .icache2mem_req_i (req),
        .icache2mem_addr_i(addr),
        .mem2icache_ack_o (ack),
        .mem2icache_data_o(line),
        .bus_req_o        (bus_req),
        .bus_addr_o       (bus_addr),
        .bus_ack_i        (bus_ack),
        .bus_rdata_i      (rdata),
        .dbg_state_o      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; addr = '0; bus_ack = 1'b0; rdata = '0;
        #12;
        checks++;
        if (bus_req !== 1'b0 || ack !== 1'b0 || line !== '0 || bus_addr !== '0 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_values: got req=%b ack=%b line=%h addr=%h st=%0d expected all 0", bus_req, ack, line, bus_addr, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // bus_ack in IDLE must be ignored
        bus_ack = 1'b1; rdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (state !== IDLE || bus_req !== 1'b0 || ack !== 1'b0 || line !== '0) begin
                errors++;
                $display("FAIL idle_ignore_ack k=%0d: got st=%0d req=%b ack=%b line=%h expected IDLE,0,0,0", k, state, bus_req, ack, line);
            end
        end
        bus_ack = 1'b0; rdata = '0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        @(negedge clk);
        req = 1'b1; addr = 32'h8000_1234;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                exp_addr = 32'h8000_1230 + 32'(4 * (k - 1));
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== exp_addr || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL zw_beat k=%0d: got req=%b addr=%h ack=%b expected 1 %h 0", k, bus_req, bus_addr, ack, exp_addr);
                end
                bus_ack = 1'b1; rdata = D_A[k-1];
            end else if (k == 5) begin
                checks++;
                if (ack !== 1'b1 || line !== LINE_A || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL zw_ack: got ack=%b line=%h req=%b expected 1 %h 0", ack, line, bus_req, LINE_A);
                end
                bus_ack = 1'b0; rdata = '0; req = 1'b0;
            end else begin
                checks++;
                if (ack !== 1'b0 || state !== IDLE || line !== LINE_A) begin
                    errors++;
                    $display("FAIL zw_after: got ack=%b st=%0d line=%h expected 0 IDLE %h", ack, state, line, LINE_A);
                end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_addr;
        int beat;
        int phase;
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_2F08;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                beat  = (k - 1) / 3;
                phase = (k - 1) % 3;
                exp_addr = 32'h0000_2F00 + 32'(4 * beat);
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== exp_addr || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL ws_beat k=%0d: got req=%b addr=%h ack=%b expected 1 %h 0", k, bus_req, bus_addr, ack, exp_addr);
                end
                bus_ack = (phase == 2);
                rdata   = (phase == 2) ? D_B[beat] : 32'hDEAD_BEEF;
            end else if (k == 13) begin
                checks++;
                if (ack !== 1'b1 || line !== LINE_B) begin
                    errors++;
                    $display("FAIL ws_ack: got ack=%b line=%h expected 1 %h", ack, line, LINE_B);
                end
                bus_ack = 1'b0; req = 1'b0;
            end else begin
                checks++;
                if (ack !== 1'b0 || state !== IDLE) begin
                    errors++;
                    $display("FAIL ws_after: got ack=%b st=%0d expected 0 IDLE", ack, state);
                end
            end
        end
    endtask

    task automatic test_kill_abort();
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_100C;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL ka_no_ack k=%0d: got %b expected 0", k, ack);
            end
            if (k <= 2) begin
                checks++;
                if (state !== FETCH || bus_addr !== 32'h0000_1000 + 32'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL ka_fetch k=%0d: got st=%0d addr=%h", k, state, bus_addr);
                end
                bus_ack = 1'b1; rdata = D_B[k-1];
            end else if (k == 3) begin
                checks++;
                if (state !== FETCH || bus_addr !== 32'h0000_1008) begin
                    errors++;
                    $display("FAIL ka_beat2: got st=%0d addr=%h expected FETCH 00001008", state, bus_addr);
                end
                bus_ack = 1'b0; req = 1'b0;
            end else if (k <= 6) begin
                checks++;
                if (state !== ABORT || bus_req !== 1'b1 || bus_addr !== 32'h0000_1008) begin
                    errors++;
                    $display("FAIL ka_hold k=%0d: got st=%0d req=%b addr=%h expected ABORT 1 00001008", k, state, bus_req, bus_addr);
                end
                bus_ack = (k == 6); rdata = 32'hBAD0_BAD0;
            end else if (k == 7) begin
                checks++;
                if (state !== IDLE || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL ka_idle: got st=%0d req=%b expected IDLE 0", state, bus_req);
                end
                bus_ack = 1'b0; req = 1'b1; addr = 32'h0000_2004;
            end else if (k == 8) begin
                checks++;
                if (state !== FETCH || bus_addr !== 32'h0000_2000) begin
                    errors++;
                    $display("FAIL ka_restart: got st=%0d addr=%h expected FETCH 00002000", state, bus_addr);
                end
                bus_ack = 1'b1; req = 1'b0;
            end else begin
                checks++;
                if (state !== IDLE || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL ka_end: got st=%0d req=%b expected IDLE 0", state, bus_req);
                end
                bus_ack = 1'b0;
            end
        end
    endtask

    task automatic test_kill_on_last();
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_3000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (state !== FETCH || bus_addr !== 32'h0000_3000 + 32'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL kl_fetch k=%0d: got st=%0d addr=%h", k, state, bus_addr);
                end
                bus_ack = 1'b1; rdata = D_A[k-1];
                if (k == 4) req = 1'b0;
            end else begin
                checks++;
                if (state !== IDLE || ack !== 1'b0 || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL kl_idle k=%0d: got st=%0d ack=%b req=%b expected IDLE 0 0", k, state, ack, bus_req);
                end
                bus_ack = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_4000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus_ack = (k <= 2); rdata = 32'hEEEE_EEEE;
        end
        #2 rst_n = 1'b0; req = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || ack !== 1'b0 || line !== '0 || bus_addr !== '0 || state !== IDLE) begin
            errors++;
            $display("FAIL ar_values: got req=%b ack=%b line=%h addr=%h st=%0d expected all 0", bus_req, ack, line, bus_addr, state);
        end
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        req = 1'b1; addr = 32'h1234_5678;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h1234_5670 + 32'(4 * (k - 1)) || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL ar_refill k=%0d: got req=%b addr=%h ack=%b", k, bus_req, bus_addr, ack);
                end
                bus_ack = 1'b1; rdata = D_A[k-1];
            end else begin
                checks++;
                if (ack !== 1'b1 || line !== LINE_A) begin
                    errors++;
                    $display("FAIL ar_ack: got ack=%b line=%h expected 1 %h", ack, line, LINE_A);
                end
                bus_ack = 1'b0; req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0040;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0040 + 32'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL b2b_first k=%0d: got req=%b addr=%h", k, bus_req, bus_addr);
                end
                bus_ack = 1'b1; rdata = D_B[k-1];
            end else if (k == 5) begin
                checks++;
                if (ack !== 1'b1 || line !== LINE_B || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ack1: got ack=%b line=%h req=%b expected 1 %h 0", ack, line, bus_req, LINE_B);
                end
                bus_ack = 1'b0; addr = 32'h0000_0080;
            end else if (k == 6) begin
                checks++;
                if (bus_req !== 1'b0 || ack !== 1'b0 || state !== IDLE) begin
                    errors++;
                    $display("FAIL b2b_gap: got req=%b ack=%b st=%0d expected 0 0 IDLE", bus_req, ack, state);
                end
            end else if (k <= 10) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0080 + 32'(4 * (k - 7)) || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second k=%0d: got req=%b addr=%h ack=%b", k, bus_req, bus_addr, ack);
                end
                bus_ack = 1'b1; rdata = D_A[k-7];
            end else if (k == 11) begin
                checks++;
                if (ack !== 1'b1 || line !== LINE_A) begin
                    errors++;
                    $display("FAIL b2b_ack2: got ack=%b line=%h expected 1 %h", ack, line, LINE_A);
                end
                bus_ack = 1'b0; req = 1'b0;
            end else begin
                checks++;
                if (ack !== 1'b0 || state !== IDLE) begin
                    errors++;
                    $display("FAIL b2b_end: got ack=%b st=%0d expected 0 IDLE", ack, state);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_kill_abort();
        test_kill_on_last();
        test_async_reset();
        test_back_to_back();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 SHALL have parameter ICACHE_LINE_WIDTH, default 128, meaning the cache line width in bits.
REQ-002 SHALL have parameter BUS_DATA_WIDTH, default 32, meaning the memory bus beat width in bits; BEATS = ICACHE_LINE_WIDTH/BUS_DATA_WIDTH, a power of 2 and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port icache2mem_req_i, input, 1 bit: line refill request from the icache controller, level, held until acked or killed.
REQ-006 SHALL have port icache2mem_addr_i, input, 32 bits: miss address; bits [log2(ICACHE_LINE_WIDTH/8)-1:0] are ignored.
REQ-007 SHALL have port mem2icache_ack_o, output, 1 bit: one-cycle pulse marking the refilled line valid.
REQ-008 SHALL have port mem2icache_data_o, output, ICACHE_LINE_WIDTH bits: the assembled line; beat 0 is in the LSBs.
REQ-009 SHALL have port bus_req_o, output, 1 bit: memory bus read request.
REQ-010 SHALL have port bus_addr_o, output, 32 bits: byte address of the current beat, aligned to BUS_DATA_WIDTH/8.
REQ-011 SHALL have port bus_ack_i, input, 1 bit: beat accepted; bus_rdata_i is valid in the same cycle.
REQ-012 SHALL have port bus_rdata_i, input, BUS_DATA_WIDTH bits: beat read data.

Function
REQ-013 SHALL implement the states IDLE, FETCH, DONE and ABORT, held in a state register.
REQ-014 In IDLE with icache2mem_req_i=1, SHALL latch the line-aligned address, clear the beat counter and go to FETCH.
REQ-015 SHALL assert bus_req_o exactly when the state is FETCH or ABORT; it is decoded from the state register only, with no combinational path from inputs.
REQ-016 SHALL drive bus_addr_o = latched line address + beat_cnt*(BUS_DATA_WIDTH/8), held stable while bus_req_o=1 and bus_ack_i=0.
REQ-017 In FETCH on bus_ack_i=1, SHALL write bus_rdata_i into line slice beat_cnt and increment beat_cnt, with beat_cnt log2(BEATS) bits wide and wrapping to 0.
REQ-018 In FETCH on bus_ack_i=1 with beat_cnt=BEATS-1 and icache2mem_req_i=1, SHALL go to DONE.
REQ-019 In DONE, SHALL drive mem2icache_ack_o=1 for exactly one cycle with mem2icache_data_o valid, then go to IDLE unconditionally.
REQ-020 SHALL give a refill latency, with a zero-wait bus, of: request sampled in IDLE at edge N; beats in cycles N+1..N+BEATS; ack in cycle N+BEATS+1.
REQ-021 On kill (icache2mem_req_i=0 while in FETCH, or at any beat acceptance): if bus_ack_i=0 that cycle, SHALL go to ABORT; if bus_ack_i=1, SHALL go to IDLE. The outstanding beat is never dropped from the bus.
REQ-022 In ABORT, SHALL hold bus_req_o and bus_addr_o until bus_ack_i=1, discard the data, go to IDLE and never assert mem2icache_ack_o.
REQ-023 SHALL NOT accept a new request in ABORT or DONE; a request present then is sampled in the following IDLE cycle.
REQ-024 SHALL update mem2icache_data_o only on accepted FETCH beats, holding it otherwise.
REQ-025 SHALL ignore bus_ack_i in IDLE and DONE.

Reset
REQ-026 On rst_ni=0, SHALL asynchronously force the state to IDLE, beat_cnt to 0, the latched address to 0, mem2icache_data_o to 0, mem2icache_ack_o to 0 and bus_req_o to 0, including mid-refill.
REQ-027 After reset release, SHALL treat the first request as a fresh refill from beat 0.

Structure
REQ-028 SHALL define type_icache_refill_states_e, ICACHE_LINE_WIDTH and ICACHE_REFILL_BEATS in the shared cache definitions package, next to type_icache_states_e.
REQ-029 SHALL be a single flat module with no sub-module; the line buffer and counter are inline.

Verification
REQ-030 Bench SHALL run: zero-wait bus, req with addr 0x8000_1234 -> bus_addr sequence 0x8000_1230, 0x8000_1234, 0x8000_1238, 0x8000_123C; ack pulse 5 cycles after the request is sampled; data = {D3,D2,D1,D0}.
REQ-031 Bench SHALL run: 2 wait cycles before each beat -> bus_addr stable during the waits; a single ack at cycle N+13.
REQ-032 Bench SHALL run: kill after beat 1 with the beat-2 ack delayed 3 cycles -> bus_req stays 1 until that ack, then IDLE; no mem2icache_ack_o; the next request restarts at beat 0.
REQ-033 Bench SHALL run: kill in the same cycle as the beat-3 ack -> IDLE; mem2icache_ack_o stays 0.
REQ-034 Bench SHALL run: rst_ni asserted asynchronously mid-beat-2 -> all outputs 0 immediately; a clean refill afterwards.
REQ-035 Bench SHALL run: back-to-back requests -> the second bus_req rises 2 cycles after the first ack, with no overlap.
